// File: rtl/console_uart_pkg.sv
// Shared constants and TX state encoding for the console UART.
// Optional feature macro: CONSOLE_UART_PARITY_EN (adds an even-parity bit, 8E1 frames).
package console_uart_pkg;

    localparam int unsigned XLEN = 32;

`ifdef CONSOLE_UART_PARITY_EN
    localparam int unsigned UART_STATE_LEN = 3;

    typedef enum logic [UART_STATE_LEN-1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_e;
`else
    localparam int unsigned UART_STATE_LEN = 2;

    typedef enum logic [UART_STATE_LEN-1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO with wrap-bit pointers; the caller must not push when full unless popping.
module console_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [Width-1:0] mem_q [Depth];

    always_comb begin
        wr_d = wr_q + (AddrW+1)'(push_i);
        rd_d = rd_q + (AddrW+1)'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; empty pointers make stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q[AddrW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q[AddrW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);

endmodule

// File: rtl/console_uart.sv
// Console write port to UART TX: byte FIFO, 8N1 framer, saturating drop counter.
// Define CONSOLE_UART_PARITY_EN for 8E1 frames with an even-parity bit.
module console_uart #(
    parameter int unsigned XLEN       = console_uart_pkg::XLEN,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            tx,
    output logic            busy,
    output logic            full,
    output logic [7:0]      overflow_cnt
);
    import console_uart_pkg::*;

    localparam int unsigned   BaudW      = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLK_DIV - 1);

    uart_state_e      state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             fifo_full, fifo_empty, pop, push;
    logic [7:0]       fifo_rdata;
    logic             unused_wdata;

    assign unused_wdata = ^console_wdata[XLEN-1:8];

    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push = console_we & (~fifo_full | pop);

    console_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (console_wdata[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CONSOLE_UART_PARITY_EN
    logic parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx      = 1'b1;
`ifdef CONSOLE_UART_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            UART_IDLE: begin
                pop = ~fifo_empty;
            end
            UART_START: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BaudReload;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            UART_DATA: begin
                tx = shift_q[0];
                if (baud_q == '0) begin
                    baud_d = BaudReload;
                    if (bit_q == 3'd7) begin
`ifdef CONSOLE_UART_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`ifdef CONSOLE_UART_PARITY_EN
            UART_PARITY: begin
                tx = parity_q;
                if (baud_q == '0) begin
                    baud_d  = BaudReload;
                    state_d = UART_STOP;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`endif
            UART_STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when more bytes wait.
                    pop     = ~fifo_empty;
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_rdata;
            bit_d   = 3'd0;
            baud_d  = BaudReload;
            state_d = UART_START;
`ifdef CONSOLE_UART_PARITY_EN
            parity_d = even_parity(fifo_rdata);
`endif
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (console_we && !push && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= '0;
`ifdef CONSOLE_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
`ifdef CONSOLE_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign busy         = (state_q != UART_IDLE) | ~fifo_empty;
    assign full         = fifo_full;
    assign overflow_cnt = ovf_q;

endmodule
